dp_share_scheduler: RTL and testbench

//  Shares one instance of the combinational 5-bit-in / 23-bit-out datapath between NUM_REQ requesters.

---
 rtl/dp_share_pkg.sv | 16 +
 rtl/dp_share_scheduler_rr_arbiter.sv | 56 +++++
 rtl/dp_share_scheduler.sv | 158 +++++++++++++++
 tb/tb_dp_share_scheduler.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_share_pkg.sv
// Shared types and default widths for the shared-datapath scheduler.
//   state_e   : scheduler FSM states
//   DEF_IN_W  : default operand width driven to the shared datapath
//   DEF_OUT_W : default result width returned by the shared datapath
package dp_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEF_IN_W  = 5;
  localparam int DEF_OUT_W = 23;

endpackage

// File: rtl/dp_share_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     in  NUM_REQ  request vector
//   ptr     in  ID_W     highest-priority requester index
//   gnt     out NUM_REQ  one-hot grant (all zero when nothing requests)
//   gnt_idx out ID_W     binary index of the granted requester
module rr_arbiter
  import dp_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [ID_W-1:0] idx_hi_s;
  logic [ID_W-1:0] idx_lo_s;
  logic            found_hi_s;

  // Downward scan: the last hit wins, so idx_lo_s ends at the lowest set bit
  // overall and idx_hi_s at the lowest set bit at or above ptr. The wrapped
  // search falls back to idx_lo_s when nothing sits at or above ptr.
  always_comb begin
    idx_hi_s   = '0;
    idx_lo_s   = '0;
    found_hi_s = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_lo_s = ID_W'(i);
        if (i >= int'(ptr)) begin
          idx_hi_s   = ID_W'(i);
          found_hi_s = 1'b1;
        end else begin
          found_hi_s = found_hi_s;
        end
      end else begin
        idx_lo_s = idx_lo_s;
      end
    end
  end

  // Final grant selection and one-hot expansion.
  always_comb begin
    gnt_idx = found_hi_s ? idx_hi_s : idx_lo_s;
    if (|req) begin
      gnt = ONE_HOT_0 << gnt_idx;
    end else begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/dp_share_scheduler.sv
// Shares one combinational datapath between NUM_REQ requesters.
// A round-robin winner's operand is registered onto dp_in, held for DP_LAT
// settle cycles, then dp_out is captured and returned with the requester id.
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/data    per-requester request; requester i at [i*IN_W +: IN_W]
//   req_ready         one-hot accept strobe (combinational, IDLE only)
//   resp_valid/id/data, resp_ready   response channel
//   dp_in / dp_out    shared datapath operand / result
//   busy              high in every state except IDLE
module dp_share_scheduler
  import dp_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int DP_LAT  = 2,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    resp_valid,
  output logic [ID_W-1:0]         resp_id,
  output logic [OUT_W-1:0]        resp_data,
  input  logic                    resp_ready,
  output logic [IN_W-1:0]         dp_in,
  input  logic [OUT_W-1:0]        dp_out,
  output logic                    busy
);

  localparam int              CNT_W    = $clog2(DP_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DP_LAT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  state_e             state_r;
  state_e             state_next_s;
  logic [ID_W-1:0]    rr_ptr_r;
  logic [ID_W-1:0]    id_r;
  logic [IN_W-1:0]    dp_in_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [OUT_W-1:0]   resp_data_r;
  logic [ID_W-1:0]    resp_id_r;
  logic               resp_valid_r;
  logic               busy_r;
  logic [NUM_REQ-1:0] gnt_s;
  logic [ID_W-1:0]    gnt_idx_s;
  logic [IN_W-1:0]    operand_s;
  logic               accept_s;
  logic               capture_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  // One-hot operand mux driven by the arbiter grant.
  always_comb begin
    operand_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_s[i]) begin
        operand_s = operand_s | req_data[i*IN_W +: IN_W];
      end else begin
        operand_s = operand_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (|req_valid) state_next_s = WAIT;
        else            state_next_s = IDLE;
      end
      WAIT: begin
        if (cnt_r == CNT_LAST) state_next_s = RESP;
        else                   state_next_s = WAIT;
      end
      RESP: begin
        if (resp_ready) state_next_s = IDLE;
        else            state_next_s = RESP;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM output decode: accept strobe, capture strobe, req_ready.
  always_comb begin
    accept_s  = 1'b0;
    capture_s = 1'b0;
    req_ready = '0;
    case (state_r)
      IDLE: begin
        accept_s  = |req_valid;
        req_ready = gnt_s;
      end
      WAIT:    capture_s = (cnt_r == CNT_LAST);
      RESP:    accept_s  = 1'b0;
      default: accept_s  = 1'b0;
    endcase
  end

  // Operand/id launch, settle counter, result capture and registered flags.
  // dp_in_r only changes on accept, so the datapath input is stable for the
  // whole settle window and the following response phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r     <= '0;
      id_r         <= '0;
      dp_in_r      <= '0;
      cnt_r        <= '0;
      resp_data_r  <= '0;
      resp_id_r    <= '0;
      resp_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      if (accept_s) begin
        dp_in_r  <= operand_s;
        id_r     <= gnt_idx_s;
        rr_ptr_r <= (gnt_idx_s == ID_LAST) ? '0 : gnt_idx_s + ID_W'(1);
        cnt_r    <= '0;
      end else if (state_r == WAIT) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (capture_s) begin
        resp_data_r <= dp_out;
        resp_id_r   <= id_r;
      end else begin
        resp_data_r <= resp_data_r;
      end
      resp_valid_r <= (state_next_s == RESP);
      busy_r       <= (state_next_s != IDLE);
    end
  end

  assign dp_in      = dp_in_r;
  assign resp_data  = resp_data_r;
  assign resp_id    = resp_id_r;
  assign resp_valid = resp_valid_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_dp_share_scheduler.sv
module tb_dp_share_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [19:0] req_data;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [22:0] resp_data;
  logic        resp_ready;
  logic [4:0]  dp_in;
  logic [22:0] dp_out;
  logic        busy;

  logic [3:0]  s_req_valid  [2];
  logic [19:0] s_req_data   [2];
  logic [3:0]  s_req_ready  [2];
  logic        s_resp_valid [2];
  logic [1:0]  s_resp_id    [2];
  logic [22:0] s_resp_data  [2];
  logic        s_resp_ready [2];
  logic [4:0]  s_dp_in      [2];
  logic [22:0] s_dp_out     [2];
  logic        s_busy       [2];

  int checks   = 0;
  int failures = 0;

  // Golden model of the shared datapath.
  function automatic logic [22:0] f(input logic [4:0] x);
    logic [22:0] xx;
    xx = {18'd0, x};
    f = (xx * xx * xx * 23'd97) ^ {x, 18'h15A5A};
  endfunction

  always #5 clk = ~clk;

  assign dp_out = f(dp_in);

  dp_share_scheduler #(.NUM_REQ(4), .IN_W(5), .OUT_W(23), .DP_LAT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_data(resp_data), .resp_ready(resp_ready), .dp_in(dp_in),
    .dp_out(dp_out), .busy(busy)
  );

  for (genvar k = 0; k < 2; k++) begin : g_sweep
    assign s_dp_out[k] = f(s_dp_in[k]);
    dp_share_scheduler #(.NUM_REQ(4), .IN_W(5), .OUT_W(23), .DP_LAT((k == 0) ? 1 : 4)) u_sw (
      .clk(clk), .rst_n(rst_n), .req_valid(s_req_valid[k]), .req_data(s_req_data[k]),
      .req_ready(s_req_ready[k]), .resp_valid(s_resp_valid[k]), .resp_id(s_resp_id[k]),
      .resp_data(s_resp_data[k]), .resp_ready(s_resp_ready[k]), .dp_in(s_dp_in[k]),
      .dp_out(s_dp_out[k]), .busy(s_busy[k])
    );
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input int max_cycles);
    int n = 0;
    while (resp_valid !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    resp_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_req_valid[k]  = '0;
      s_req_data[k]   = '0;
      s_resp_ready[k] = 1'b0;
    end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (dp_in !== 5'd0) begin failures++; $display("FAIL reset_dp_in got=%h exp=0", dp_in); end
    checks++; if (resp_data !== 23'd0 || resp_id !== 2'd0) begin failures++; $display("FAIL reset_resp got=%h/%0d exp=0/0", resp_data, resp_id); end
  endtask

  task automatic test_single;
    do_reset();
    req_data[14:10] = 5'h13;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    #1;
    checks++; if (dp_in !== 5'h13) begin failures++; $display("FAIL single_dp_in got=%h exp=13", dp_in); end
    checks++; if (busy !== 1'b1 || resp_valid !== 1'b0 || req_ready !== 4'b0000) begin failures++; $display("FAIL single_c1 busy=%b rv=%b rr=%b exp=1/0/0000", busy, resp_valid, req_ready); end
    tick();
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL single_c2_valid got=%b exp=0", resp_valid); end
    tick();
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL single_c3_valid got=%b exp=1", resp_valid); end
    checks++; if (resp_id !== 2'd2) begin failures++; $display("FAIL single_id got=%0d exp=2", resp_id); end
    checks++; if (resp_data !== f(5'h13)) begin failures++; $display("FAIL single_data got=%h exp=%h", resp_data, f(5'h13)); end
    resp_ready = 1'b1;
    tick();
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_done rv=%b busy=%b exp=0/0", resp_valid, busy); end
    resp_ready = 1'b0;
  endtask

  task automatic test_contention;
    logic [4:0] opv [4];
    logic [3:0] exp_gnt;
    int n;
    int g;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      opv[i] = 5'(i * 7 + 3);
      req_data[i*5 +: 5] = opv[i];
    end
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      n = 0;
      while (req_ready === 4'b0000 && n < 20) begin
        tick();
        n++;
      end
      exp_gnt = 4'b0001 << g;
      checks++; if (req_ready !== exp_gnt) begin failures++; $display("FAIL contention_grant%0d got=%b exp=%b", k, req_ready, exp_gnt); end
      tick();
      wait_resp(10);
      checks++; if (resp_valid !== 1'b1 || resp_id !== 2'(g)) begin failures++; $display("FAIL contention_id%0d rv=%b got=%0d exp=%0d", k, resp_valid, resp_id, g); end
      checks++; if (resp_data !== f(opv[g])) begin failures++; $display("FAIL contention_data%0d got=%h exp=%h", k, resp_data, f(opv[g])); end
      tick();
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_backpressure;
    do_reset();
    req_data[4:0] = 5'h0A;
    req_data[9:5] = 5'h15;
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_first_ready got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'b0010;
    wait_resp(10);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== f(5'h0A) || req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_hold%0d rv=%b id=%0d data=%h rr=%b exp=1/0/%h/0000", i, resp_valid, resp_id, resp_data, req_ready, f(5'h0A));
      end
      tick();
    end
    resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_no_bypass got=%b exp=0000", req_ready); end
    tick();
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_next_accept got=%b exp=0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    wait_resp(10);
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== f(5'h15)) begin failures++; $display("FAIL bp_second rv=%b id=%0d data=%h exp=1/1/%h", resp_valid, resp_id, resp_data, f(5'h15)); end
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_ptr_wrap;
    do_reset();
    req_data[4:0]   = 5'h01;
    req_data[19:15] = 5'h1F;
    resp_ready = 1'b1;
    req_valid  = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL wrap_first got=%b exp=1000", req_ready); end
    tick();
    req_valid = 4'b0000;
    wait_resp(10);
    tick();
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL wrap_to0 got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    wait_resp(10);
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== f(5'h01)) begin failures++; $display("FAIL wrap_resp0 rv=%b id=%0d data=%h", resp_valid, resp_id, resp_data); end
    tick();
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL wrap_to3 got=%b exp=1000", req_ready); end
    tick();
    req_valid = 4'b0000;
    wait_resp(10);
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_data !== f(5'h1F)) begin failures++; $display("FAIL wrap_resp3 rv=%b id=%0d data=%h", resp_valid, resp_id, resp_data); end
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    do_reset();
    req_data[9:5]   = 5'h1B;
    req_data[14:10] = 5'h07;
    resp_ready = 1'b1;
    req_valid  = 4'b0010;
    #1;
    tick();
    req_valid = 4'b0000;
    wait_resp(10);
    tick();
    resp_ready = 1'b0;
    req_valid  = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL mid_accept got=%b exp=0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    rst_n     = 1'b0;
    #1;
    checks++; if (dp_in !== 5'd0 || busy !== 1'b0 || resp_valid !== 1'b0) begin failures++; $display("FAIL mid_clear dp_in=%h busy=%b rv=%b exp=0/0/0", dp_in, busy, resp_valid); end
    checks++; if (resp_data !== 23'd0 || resp_id !== 2'd0 || req_ready !== 4'b0000) begin failures++; $display("FAIL mid_clear_resp data=%h id=%0d rr=%b exp=0/0/0000", resp_data, resp_id, req_ready); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL mid_no_resp%0d got=%b exp=0", i, resp_valid); end
    end
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_ptr_reset got=%b exp=0001", req_ready); end
    req_valid = 4'b0000;
  endtask

  task automatic test_sweep(input int k, input int lat);
    int n;
    do_reset();
    s_resp_ready[k] = 1'b1;
    for (int x = 0; x < 32; x++) begin
      s_req_data[k]  = {10'd0, 5'(x), 5'd0};
      s_req_valid[k] = 4'b0010;
      #1;
      checks++; if (s_req_ready[k] !== 4'b0010) begin failures++; $display("FAIL sweep%0d_ready x=%0d got=%b exp=0010", lat, x, s_req_ready[k]); end
      tick();
      s_req_valid[k] = 4'b0000;
      n = 1;
      while (s_resp_valid[k] !== 1'b1 && n < 12) begin
        tick();
        n++;
      end
      checks++; if (n != lat + 1) begin failures++; $display("FAIL sweep%0d_latency x=%0d got=%0d exp=%0d", lat, x, n, lat + 1); end
      checks++; if (s_resp_data[k] !== f(5'(x)) || s_resp_id[k] !== 2'd1) begin failures++; $display("FAIL sweep%0d_data x=%0d got=%h/%0d exp=%h/1", lat, x, s_resp_data[k], s_resp_id[k], f(5'(x))); end
      tick();
    end
    s_resp_ready[k] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_ptr_wrap();
    test_reset_mid_wait();
    test_sweep(0, 1);
    test_sweep(1, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
